// File: rtl/sipo_word_arbiter_if.sv
// Bundle between byte requesters, the shared word packer and the word consumer.
// Handshakes: a byte moves when src_valid[i] & src_ready[i] at a rising clk edge; a word moves when out_valid & out_ready.
interface sipo_word_arbiter_if #(
   parameter int NUM_SRC = 4,
   parameter int SRC_W   = 3
);
   logic [NUM_SRC-1:0]   src_valid;
   logic [8*NUM_SRC-1:0] src_data;
   logic [NUM_SRC-1:0]   src_last;
   logic [NUM_SRC-1:0]   src_ready;
   logic                 out_valid;
   logic                 out_ready;
   logic [63:0]          out_word;
   logic [SRC_W-1:0]     out_src;
   logic [3:0]           out_bytes;
   logic                 busy;
   logic [15:0]          word_count;
   // Counter preload hook and FSM state visibility.
   logic                 cnt_load;
   logic [15:0]          cnt_load_val;
   logic [1:0]           dbg_state;

   modport master (
      output src_valid, src_data, src_last, out_ready, cnt_load, cnt_load_val,
      input  src_ready, out_valid, out_word, out_src, out_bytes, busy, word_count, dbg_state
   );

   modport slave (
      input  src_valid, src_data, src_last, out_ready, cnt_load, cnt_load_val,
      output src_ready, out_valid, out_word, out_src, out_bytes, busy, word_count, dbg_state
   );
endinterface

// File: rtl/sipo_word_arbiter.sv
// Round-robin owner of one 64-bit byte-to-word packer; grants a requester for a whole
// word session (up to 8 bytes) and presents the tagged word on a valid/ready output.
module sipo_word_arbiter #(
   parameter int NUM_SRC = 4,
   parameter int SRC_W   = 3
) (
   input  logic               clk,
   input  logic               rst,
   sipo_word_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      OUTPUT  = 2'd2
   } state_t;

   state_t             state;
   logic [SRC_W-1:0]   grant;
   logic [SRC_W-1:0]   rr_ptr;
   logic [63:0]        word_r;
   logic [3:0]         cnt;
   logic [NUM_SRC-1:0] src_ready_r;
   logic               out_valid_r;
   logic               busy_r;
   logic [63:0]        out_word_r;
   logic [SRC_W-1:0]   out_src_r;
   logic [3:0]         out_bytes_r;
   logic [15:0]        word_count_r;

   logic               pick_found;
   logic [SRC_W-1:0]   pick_idx;
   logic [NUM_SRC-1:0] ready_nx;
   logic               g_valid;
   logic               g_last;
   logic [7:0]         g_byte;
   logic [63:0]        word_nx;

   // Descending scan so the last hit is the lowest index: hi_* wins at or above rr_ptr, lo_* is the wrap-around fallback.
   always_comb begin
      logic             hi_found;
      logic [SRC_W-1:0] hi_idx;
      logic [SRC_W-1:0] lo_idx;
      hi_found   = 1'b0;
      hi_idx     = '0;
      lo_idx     = '0;
      pick_found = 1'b0;
      for (int j = NUM_SRC - 1; j >= 0; j--) begin
         if (bus.src_valid[j]) begin
            pick_found = 1'b1;
            lo_idx     = SRC_W'(j);
            if (SRC_W'(j) >= rr_ptr) begin
               hi_found = 1'b1;
               hi_idx   = SRC_W'(j);
            end
         end
      end
      pick_idx = hi_found ? hi_idx : lo_idx;
      ready_nx = '0;
      for (int j = 0; j < NUM_SRC; j++) begin
         ready_nx[j] = (pick_idx == SRC_W'(j));
      end
   end

   always_comb begin
      g_valid = 1'b0;
      g_last  = 1'b0;
      g_byte  = 8'h00;
      for (int j = 0; j < NUM_SRC; j++) begin
         if (grant == SRC_W'(j)) begin
            g_valid = bus.src_valid[j];
            g_last  = bus.src_last[j];
            g_byte  = bus.src_data[8*j +: 8];
         end
      end
      word_nx = {word_r[55:0], g_byte};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         grant        <= '0;
         rr_ptr       <= '0;
         word_r       <= '0;
         cnt          <= '0;
         src_ready_r  <= '0;
         out_valid_r  <= 1'b0;
         busy_r       <= 1'b0;
         out_word_r   <= '0;
         out_src_r    <= '0;
         out_bytes_r  <= '0;
         word_count_r <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  grant       <= pick_idx;
                  word_r      <= '0;
                  cnt         <= '0;
                  src_ready_r <= ready_nx;
                  busy_r      <= 1'b1;
                  state       <= COLLECT;
               end
            end
            COLLECT: begin
               // src_ready[grant] is already high here, so valid alone means accept.
               if (g_valid) begin
                  word_r <= word_nx;
                  cnt    <= cnt + 4'd1;
                  if (cnt == 4'd7 || g_last) begin
                     src_ready_r <= '0;
                     out_valid_r <= 1'b1;
                     out_word_r  <= word_nx;
                     out_src_r   <= grant;
                     out_bytes_r <= cnt + 4'd1;
                     state       <= OUTPUT;
                  end
               end
            end
            OUTPUT: begin
               if (bus.out_ready) begin
                  out_valid_r  <= 1'b0;
                  busy_r       <= 1'b0;
                  rr_ptr       <= (grant == SRC_W'(NUM_SRC - 1)) ? '0 : grant + SRC_W'(1);
                  word_count_r <= word_count_r + 16'd1;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         if (bus.cnt_load) begin
            word_count_r <= bus.cnt_load_val;
         end
      end
   end

   assign bus.src_ready  = src_ready_r;
   assign bus.out_valid  = out_valid_r;
   assign bus.out_word   = out_word_r;
   assign bus.out_src    = out_src_r;
   assign bus.out_bytes  = out_bytes_r;
   assign bus.busy       = busy_r;
   assign bus.word_count = word_count_r;
   assign bus.dbg_state  = state;

endmodule

// File: tb/tb_sipo_word_arbiter.sv
// Directed bench for sipo_word_arbiter: stimulus pushes expected words into exp_q and a
// negedge monitor pops and compares on every output handshake.
module tb_sipo_word_arbiter;
   localparam int NUM_SRC = 4;
   localparam int SRC_W   = 3;
   localparam int W       = 64 + SRC_W + 4;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sipo_word_arbiter_if #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) bus ();

   sipo_word_arbiter #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;
   int hs_count = 0;
   int exp_hs   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [W-1:0] pack(input logic [63:0] w, input logic [SRC_W-1:0] s, input logic [3:0] b);
      return {w, s, b};
   endfunction

   // Monitor: scoreboard pops, hold stability under backpressure, src_ready legality.
   initial begin
      logic [W-1:0] prev;
      logic [W-1:0] cur;
      logic [W-1:0] e;
      logic         hold;
      hold = 1'b0;
      prev = '0;
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            hold = 1'b0;
         end else begin
            cur = {bus.out_word, bus.out_src, bus.out_bytes};
            check("src_ready_onehot0", 64'($onehot0(bus.src_ready)), 64'd1);
            if (bus.out_valid) check("src_ready_in_output", 64'(bus.src_ready), 64'd0);
            if (hold && bus.out_valid) begin
               check("out_word_stable", cur[W-1:7], prev[W-1:7]);
               check("out_tag_stable", 64'(cur[6:0]), 64'(prev[6:0]));
            end
            if (bus.out_valid && bus.out_ready) begin
               hs_count++;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_word: got %h expected no word", cur[W-1:7]);
               end else begin
                  e = exp_q.pop_front();
                  check("out_word", cur[W-1:7], e[W-1:7]);
                  check("out_src", 64'(cur[6:4]), 64'(e[6:4]));
                  check("out_bytes", 64'(cur[3:0]), 64'(e[3:0]));
               end
            end
            hold = bus.out_valid && !bus.out_ready;
            prev = cur;
         end
      end
   end

   task automatic idle_inputs();
      bus.src_valid    = '0;
      bus.src_data     = '0;
      bus.src_last     = '0;
      bus.out_ready    = 1'b1;
      bus.cnt_load     = 1'b0;
      bus.cnt_load_val = '0;
   endtask

   // Called at a negedge; returns at the negedge after the byte is accepted.
   task automatic send_byte(input int s, input logic [7:0] b, input logic last);
      int t;
      t = 0;
      bus.src_valid[s]      = 1'b1;
      bus.src_data[8*s +: 8] = b;
      bus.src_last[s]       = last;
      while (!bus.src_ready[s] && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         n_checks++;
         $display("FAIL send_byte_timeout: src %0d got no ready expected ready within 50 cycles", s);
      end else begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic release_src(input int s);
      bus.src_valid[s] = 1'b0;
      bus.src_last[s]  = 1'b0;
   endtask

   task automatic wait_drain(input int n_hs);
      int t;
      t = 0;
      while (!(hs_count >= n_hs && !bus.out_valid && !bus.busy) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         n_checks++;
         $display("FAIL drain_timeout: got %0d handshakes expected %0d", hs_count, n_hs);
      end
   endtask

   // Holds every listed source valid with a 1-byte word until n handshakes are seen.
   task automatic contend(input logic [NUM_SRC-1:0] mask, input int n);
      int seen;
      int t;
      seen = 0;
      t    = 0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (mask[i]) begin
            bus.src_valid[i]       = 1'b1;
            bus.src_last[i]        = 1'b1;
            bus.src_data[8*i +: 8] = 8'hA0 + 8'(i);
         end
      end
      while (seen < n && t < 200) begin
         @(negedge clk);
         if (bus.out_valid && bus.out_ready) seen++;
         t++;
      end
      if (seen < n) begin
         n_checks++;
         $display("FAIL contend_timeout: got %0d words expected %0d", seen, n);
      end
      @(negedge clk);
      for (int i = 0; i < NUM_SRC; i++) begin
         if (mask[i]) release_src(i);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      rst = 1'b1;
      idle_inputs();
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_src_ready", 64'(bus.src_ready), 64'd0);
      check("reset_out_valid", 64'(bus.out_valid), 64'd0);
      check("reset_out_word", bus.out_word, 64'd0);
      check("reset_busy", 64'(bus.busy), 64'd0);
      check("reset_word_count", 64'(bus.word_count), 64'd0);
      check("reset_state", 64'(bus.dbg_state), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      // Full word from source 2 with latency measured from the grant edge.
      exp_q.push_back(pack(64'h1122334455667788, 3'd2, 4'd8));
      exp_hs += 1;
      c0 = cyc;
      for (int k = 0; k < 8; k++) send_byte(2, 8'(8'h11 * (k + 1)), 1'b0);
      release_src(2);
      check("out_valid_latency", 64'(cyc - c0), 64'd9);
      check("out_valid_at_latency", 64'(bus.out_valid), 64'd1);
      wait_drain(exp_hs);
      check("word_count_after_1", 64'(bus.word_count), 64'd1);

      // Short word: three bytes, last on the third.
      exp_q.push_back(pack(64'h0000000000AABBCC, 3'd0, 4'd3));
      exp_hs += 1;
      send_byte(0, 8'hAA, 1'b0);
      send_byte(0, 8'hBB, 1'b0);
      send_byte(0, 8'hCC, 1'b1);
      release_src(0);
      wait_drain(exp_hs);
      check("word_count_after_2", 64'(bus.word_count), 64'd2);

      // Round-robin from a fresh pointer with all sources requesting.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(pack(64'(8'hA0 + 8'(i % 4)), SRC_W'(i % 4), 4'd1));
      end
      exp_hs += 5;
      contend(4'b1111, 5);
      wait_drain(exp_hs);
      check("word_count_after_rr", 64'(bus.word_count), 64'd5);

      // Source stall mid-word then consumer backpressure.
      exp_q.push_back(pack(64'h0102030405060708, 3'd2, 4'd8));
      exp_hs += 1;
      bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) send_byte(2, 8'(k + 1), 1'b0);
      release_src(2);
      repeat (5) @(negedge clk);
      check("stall_no_output", 64'(bus.out_valid), 64'd0);
      check("stall_busy", 64'(bus.busy), 64'd1);
      for (int k = 3; k < 8; k++) send_byte(2, 8'(k + 1), 1'b0);
      bus.src_valid[2]       = 1'b1;
      bus.src_data[8*2 +: 8] = 8'hEE;
      bus.src_last[2]        = 1'b1;
      repeat (7) @(negedge clk);
      check("backpressure_hold", 64'(bus.out_valid), 64'd1);
      check("backpressure_word", bus.out_word, 64'h0102030405060708);
      release_src(2);
      bus.out_ready = 1'b1;
      wait_drain(exp_hs);

      // Asynchronous reset in the middle of a source 1 session.
      for (int k = 0; k < 4; k++) send_byte(1, 8'(8'h30 + k), 1'b0);
      release_src(1);
      #2 rst = 1'b0;
      #1;
      check("midreset_src_ready", 64'(bus.src_ready), 64'd0);
      check("midreset_busy", 64'(bus.busy), 64'd0);
      check("midreset_out_valid", 64'(bus.out_valid), 64'd0);
      check("midreset_out_word", bus.out_word, 64'd0);
      check("midreset_out_src", 64'(bus.out_src), 64'd0);
      check("midreset_out_bytes", 64'(bus.out_bytes), 64'd0);
      check("midreset_word_count", 64'(bus.word_count), 64'd0);
      check("midreset_state", 64'(bus.dbg_state), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Pointer back at 0: with 2 and 3 requesting, 2 goes first.
      exp_q.push_back(pack(64'h00000000000000A2, 3'd2, 4'd1));
      exp_q.push_back(pack(64'h00000000000000A3, 3'd3, 4'd1));
      exp_hs += 2;
      contend(4'b1100, 2);
      wait_drain(exp_hs);
      exp_q.push_back(pack(64'h0000000000003132, 3'd3, 4'd2));
      exp_hs += 1;
      send_byte(3, 8'h31, 1'b0);
      send_byte(3, 8'h32, 1'b1);
      release_src(3);
      wait_drain(exp_hs);
      check("word_count_after_midreset", 64'(bus.word_count), 64'd3);

      // Counter wrap from a preloaded value.
      bus.cnt_load     = 1'b1;
      bus.cnt_load_val = 16'hFFFE;
      @(negedge clk);
      bus.cnt_load = 1'b0;
      check("wc_preload", 64'(bus.word_count), 64'hFFFE);
      exp_q.push_back(pack(64'h000000000000005A, 3'd0, 4'd1));
      exp_hs += 1;
      send_byte(0, 8'h5A, 1'b1);
      release_src(0);
      wait_drain(exp_hs);
      check("wc_ffff", 64'(bus.word_count), 64'hFFFF);
      exp_q.push_back(pack(64'h00000000000000A5, 3'd1, 4'd1));
      exp_hs += 1;
      send_byte(1, 8'hA5, 1'b1);
      release_src(1);
      wait_drain(exp_hs);
      check("wc_wrap", 64'(bus.word_count), 64'h0000);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      check("handshake_total", 64'(hs_count), 64'(exp_hs));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
